// File: rtl/mci_mcu_sram_arb.sv
// Purpose : MCU SRAM front end. Zero-fills the array after reset, then shares the
//           single SRAM port between r0 (MCU LSU/IFU, high priority) and r1 (AXI/DMA, low priority).
// Latency : grant is combinational in the request cycle; read data returns 1 cycle after the read grant.
// Backpr. : requesters hold req until gnt; read returns have no backpressure (rvalid must be accepted).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   init_done                     zero-fill complete, arbitration running
//   rX_req/we/addr/wdata          request from requester X ({ecc,data} write word)
//   rX_gnt                        request accepted this cycle
//   rX_rvalid/rdata               read return routed to the requester that issued the read
//   sram_cs/we/addr/wdata/rdata   SRAM port, rdata valid 1 cycle after cs && !we
module mci_mcu_sram_arb #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ECC_WIDTH    = 7,
  parameter int DEPTH        = 65536,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            init_done,

  input  logic                            r0_req,
  input  logic                            r0_we,
  input  logic [ADDR_WIDTH-1:0]           r0_addr,
  input  logic [ECC_WIDTH+DATA_WIDTH-1:0] r0_wdata,
  output logic                            r0_gnt,
  output logic                            r0_rvalid,
  output logic [ECC_WIDTH+DATA_WIDTH-1:0] r0_rdata,

  input  logic                            r1_req,
  input  logic                            r1_we,
  input  logic [ADDR_WIDTH-1:0]           r1_addr,
  input  logic [ECC_WIDTH+DATA_WIDTH-1:0] r1_wdata,
  output logic                            r1_gnt,
  output logic                            r1_rvalid,
  output logic [ECC_WIDTH+DATA_WIDTH-1:0] r1_rdata,

  output logic                            sram_cs,
  output logic                            sram_we,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic [ECC_WIDTH+DATA_WIDTH-1:0] sram_wdata,
  input  logic [ECC_WIDTH+DATA_WIDTH-1:0] sram_rdata
);

  localparam int WORD_W = ECC_WIDTH + DATA_WIDTH;
  // Wide enough to hold STARVE_LIMIT itself (the saturation value).
  localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  rd_pending;
  logic                  rd_owner;    // 0 = r0, 1 = r1
  logic                  win0;
  logic                  win1;
  logic                  starved;

  assign starved = (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Counter only advances while zero-filling; its value after init is don't-care.
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end

      // Consecutive denied cycles of r1; any r1 grant or idle r1 restarts the count.
      if ((state == ST_ARB) && r1_req && !win1) begin
        if (!starved) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end

      rd_pending <= (win0 && !r0_we) || (win1 && !r1_we);
      if (win1 && !r1_we) begin
        rd_owner <= 1'b1;
      end else if (win0 && !r0_we) begin
        rd_owner <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    win0       = 1'b0;
    win1       = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;

    case (state)
      ST_INIT: begin
        sram_cs   = 1'b1;
        sram_we   = 1'b1;
        sram_addr = init_cnt;
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        // r1 takes the slot when r0 is idle or when r1 has waited long enough.
        win1 = r1_req && (starved || !r0_req);
        win0 = r0_req && !win1;
        if (win0) begin
          sram_cs    = 1'b1;
          sram_we    = r0_we;
          sram_addr  = r0_addr;
          sram_wdata = r0_wdata;
        end else if (win1) begin
          sram_cs    = 1'b1;
          sram_we    = r1_we;
          sram_addr  = r1_addr;
          sram_wdata = r1_wdata;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase

    // Outputs are forced quiet in the reset cycle itself, not only after it.
    if (rst) begin
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
    end
  end

  assign init_done = (state == ST_ARB) && !rst;
  assign r0_gnt    = win0 && !rst;
  assign r1_gnt    = win1 && !rst;
  assign r0_rvalid = rd_pending && !rd_owner && !rst;
  assign r1_rvalid = rd_pending &&  rd_owner && !rst;
  assign r0_rdata  = r0_rvalid ? sram_rdata : {WORD_W{1'b0}};
  assign r1_rdata  = r1_rvalid ? sram_rdata : {WORD_W{1'b0}};

endmodule
